// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcodes, funct codes and datapath mux selects.
package mips_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH  = 4'd0;
   localparam state_t S_DECODE = 4'd1;
   localparam state_t S_MEMADR = 4'd2;
   localparam state_t S_MEMRD  = 4'd3;
   localparam state_t S_MEMWB  = 4'd4;
   localparam state_t S_MEMWR  = 4'd5;
   localparam state_t S_EXEC   = 4'd6;
   localparam state_t S_ALUWB  = 4'd7;
   localparam state_t S_BRANCH = 4'd8;
   localparam state_t S_ADDIEX = 4'd9;
   localparam state_t S_ADDIWB = 4'd10;
   localparam state_t S_JUMP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] PC_ALU = 2'b00;
   localparam logic [1:0] PC_OUT = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and memory
// handshake in, mux selects, enables and status out.
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic             mem_req;
   logic             iord;
   logic             memwrite;
   logic             irwrite;
   logic             pcen;
   logic             regdst;
   logic             memtoreg;
   logic             regwrite;
   logic             alusrca;
   logic [1:0]       alusrcb;
   logic [1:0]       pcsrc;
   logic [2:0]       aluctrl;
   logic             illegal;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, funct, zero, mem_ready,
      output mem_req, iord, memwrite, irwrite, pcen,
      output regdst, memtoreg, regwrite, alusrca,
      output alusrcb, pcsrc, aluctrl, illegal, instret
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  mem_req, iord, memwrite, irwrite, pcen,
      input  regdst, memtoreg, regwrite, alusrca,
      input  alusrcb, pcsrc, aluctrl, illegal, instret
   );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type funct to ALU control; valid drops for unknown funct.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] aluctrl,
   output logic       valid
);
   always_comb begin
      aluctrl = ALU_ADD;
      valid   = 1'b1;
      case (funct)
         F_ADD:   aluctrl = ALU_ADD;
         F_SUB:   aluctrl = ALU_SUB;
         F_AND:   aluctrl = ALU_AND;
         F_OR:    aluctrl = ALU_OR;
         F_SLT:   aluctrl = ALU_SLT;
         default: valid   = 1'b0;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath, with
// retired-instruction counter and sticky illegal flag.
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic                     clk,
   input logic                     rst,
   multicycle_controller_if.master bus
);
   state_t           state;
   state_t           next;
   logic [CNT_W-1:0] cnt;
   logic             ill;
   logic             retire;
   logic             bad;
   logic             pcwrite;
   logic             branch;
   logic [2:0]       f_alu;
   logic             f_ok;

   alu_decoder u_dec (
      .funct   (bus.funct),
      .aluctrl (f_alu),
      .valid   (f_ok)
   );

   always_comb begin
      next   = state;
      retire = 1'b0;
      bad    = 1'b0;
      case (state)
         S_FETCH:  if (bus.mem_ready) next = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: next = S_MEMADR;
               OP_RTYPE:     next = S_EXEC;
               OP_BEQ:       next = S_BRANCH;
               OP_ADDI:      next = S_ADDIEX;
               OP_J:         next = S_JUMP;
               default: begin
                  next = S_FETCH;
                  bad  = 1'b1;
               end
            endcase
         end
         S_MEMADR: next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (bus.mem_ready) next = S_MEMWB;
         S_MEMWR: begin
            if (bus.mem_ready) begin
               next   = S_FETCH;
               retire = 1'b1;
            end
         end
         S_EXEC: begin
            next = f_ok ? S_ALUWB : S_FETCH;
            bad  = ~f_ok;
         end
         S_ADDIEX: next = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
            next   = S_FETCH;
            retire = 1'b1;
         end
         default:  next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         cnt   <= '0;
         ill   <= 1'b0;
      end else begin
         state <= next;
         if (retire) cnt <= cnt + CNT_W'(1);
         if (bad) ill <= 1'b1;
      end
   end

   always_comb begin
      bus.mem_req  = 1'b0;
      bus.iord     = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = SRCB_B;
      bus.pcsrc    = PC_ALU;
      bus.aluctrl  = ALU_AND;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      case (state)
         S_FETCH: begin
            bus.mem_req = 1'b1;
            bus.alusrcb = SRCB_4;
            bus.aluctrl = ALU_ADD;
            bus.irwrite = bus.mem_ready;
            pcwrite     = bus.mem_ready;
         end
         S_DECODE: begin
            bus.alusrcb = SRCB_IMM2;
            bus.aluctrl = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            bus.aluctrl = ALU_ADD;
         end
         S_MEMRD: begin
            bus.mem_req = 1'b1;
            bus.iord    = 1'b1;
         end
         S_MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_req  = 1'b1;
            bus.iord     = 1'b1;
            bus.memwrite = bus.mem_ready;
         end
         S_EXEC: begin
            bus.alusrca = 1'b1;
            bus.aluctrl = f_alu;
         end
         S_ALUWB: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
         end
         S_BRANCH: begin
            bus.alusrca = 1'b1;
            bus.aluctrl = ALU_SUB;
            bus.pcsrc   = PC_OUT;
            branch      = 1'b1;
         end
         S_ADDIWB: bus.regwrite = 1'b1;
         S_JUMP: begin
            bus.pcsrc = PC_JMP;
            pcwrite   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.pcen    = pcwrite | (branch & bus.zero);
   assign bus.illegal = ill;
   assign bus.instret = cnt;
endmodule
